// File: rtl/fade_gen.sv
// Brightness envelope generator: rise / hold-high / fall / hold-low duty word for the pwm block.
// Optional gamma mapping of the output is enabled by defining FADE_GEN_GAMMA_EN.
module fade_gen #(
    parameter int unsigned MIN_DUTY        = 1,
    parameter int unsigned MAX_DUTY        = 254,
    parameter int unsigned STEP            = 1,
    parameter int unsigned HOLD_HIGH_TICKS = 0,
    parameter int unsigned HOLD_LOW_TICKS  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       tick,
    input  logic       start,
    input  logic       oneShot,
    output logic [7:0] dutyCycle,
    output logic       busy,
    output logic       cycleDone
);

    localparam int unsigned LVL_W = 8;
    localparam int unsigned CNT_W = 16;

    localparam logic [LVL_W-1:0] MIN_L    = LVL_W'(MIN_DUTY);
    localparam logic [LVL_W-1:0] MAX_L    = LVL_W'(MAX_DUTY);
    localparam logic [LVL_W-1:0] STEP_L   = LVL_W'(STEP);
    localparam logic [LVL_W:0]   STEP_W   = (LVL_W+1)'(STEP);
    localparam logic [LVL_W:0]   MAX_W    = (LVL_W+1)'(MAX_DUTY);
    localparam logic [LVL_W:0]   FALL_LIM = (LVL_W+1)'(MIN_DUTY + STEP);
    localparam logic [CNT_W:0]   HH_CNT   = (CNT_W+1)'(HOLD_HIGH_TICKS);
    localparam logic [CNT_W:0]   HL_CNT   = (CNT_W+1)'(HOLD_LOW_TICKS);
    localparam logic             HAS_HH   = (HOLD_HIGH_TICKS != 0);
    localparam logic             HAS_HL   = (HOLD_LOW_TICKS != 0);

    typedef enum logic [2:0] {IDLE, RISE, HOLD_HI, FALL, HOLD_LO} state_t;

    state_t             state;
    logic [LVL_W-1:0]   level;
    logic [CNT_W-1:0]   holdCnt;

    logic               startOk;
    logic [LVL_W:0]     riseSum;
    logic [CNT_W:0]     cntNext;
    state_t             endState;
    logic               endBusy;

    // 9-bit / 17-bit arithmetic so limits never wrap
    assign startOk  = enable && (oneShot ? start : 1'b1);
    assign riseSum  = {1'b0, level} + STEP_W;
    assign cntNext  = {1'b0, holdCnt} + (CNT_W+1)'(1);
    assign endState = (oneShot || !enable) ? IDLE : RISE;
    assign endBusy  = (endState != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            level     <= MIN_L;
            holdCnt   <= '0;
            busy      <= 1'b0;
            cycleDone <= 1'b0;
        end else begin
            cycleDone <= 1'b0;
            case (state)
                IDLE: begin
                    level   <= MIN_L;
                    holdCnt <= '0;
                    if (startOk) begin
                        state <= RISE;
                        busy  <= 1'b1;
                    end
                end
                RISE: if (tick) begin
                    if (riseSum >= MAX_W) begin
                        level   <= MAX_L;
                        holdCnt <= '0;
                        state   <= HAS_HH ? HOLD_HI : FALL;
                    end else begin
                        level <= riseSum[LVL_W-1:0];
                    end
                end
                HOLD_HI: if (tick) begin
                    if (cntNext == HH_CNT) begin
                        holdCnt <= '0;
                        state   <= FALL;
                    end else begin
                        holdCnt <= cntNext[CNT_W-1:0];
                    end
                end
                FALL: if (tick) begin
                    if ({1'b0, level} <= FALL_LIM) begin
                        level   <= MIN_L;
                        holdCnt <= '0;
                        if (HAS_HL) begin
                            state <= HOLD_LO;
                        end else begin
                            cycleDone <= 1'b1;
                            state     <= endState;
                            busy      <= endBusy;
                        end
                    end else begin
                        level <= level - STEP_L;
                    end
                end
                HOLD_LO: if (tick) begin
                    if (cntNext == HL_CNT) begin
                        holdCnt   <= '0;
                        cycleDone <= 1'b1;
                        state     <= endState;
                        busy      <= endBusy;
                    end else begin
                        holdCnt <= cntNext[CNT_W-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FADE_GEN_GAMMA_EN
    logic [15:0] levelSq;

    // Squared-level mapping, rounded up so that 1 still maps to 1
    assign levelSq = 16'(level) * 16'(level) + 16'd255;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dutyCycle <= '0;
        else     dutyCycle <= 8'(levelSq >> 8);
    end
`else
    assign dutyCycle = level;
`endif

endmodule

// File: tb/tb_fade_gen.sv
// Self-checking bench for fade_gen: three parameter sets, table vectors and a scoreboard queue.
module tb_fade_gen;

    logic clk, rst, enable, tick, start, oneShot;
    logic [7:0] duty0, duty1, duty2;
    logic busy0, busy1, busy2, done0, done1, done2;

    int sel;
    logic [7:0] selDuty;
    logic selBusy, selDone;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] duty;
        logic       done;
        logic       busy;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic st;
        int   duty;
        logic done;
        logic busy;
    } vec_t;
    vec_t tbl[12];

    fade_gen dut0 (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick), .start(start), .oneShot(oneShot),
        .dutyCycle(duty0), .busy(busy0), .cycleDone(done0)
    );

    fade_gen #(.MIN_DUTY(0), .MAX_DUTY(10), .STEP(3), .HOLD_HIGH_TICKS(2), .HOLD_LOW_TICKS(2)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick), .start(start), .oneShot(oneShot),
        .dutyCycle(duty1), .busy(busy1), .cycleDone(done1)
    );

    fade_gen #(.MIN_DUTY(0), .MAX_DUTY(255), .STEP(255)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick), .start(start), .oneShot(oneShot),
        .dutyCycle(duty2), .busy(busy2), .cycleDone(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        selDuty = duty2;
        selBusy = busy2;
        selDone = done2;
        case (sel)
            0: begin selDuty = duty0; selBusy = busy0; selDone = done0; end
            1: begin selDuty = duty1; selBusy = busy1; selDone = done1; end
            default: ;
        endcase
    end

    function automatic int g(input int l);
`ifdef FADE_GEN_GAMMA_EN
        return (l * l + 255) >> 8;
`else
        return l;
`endif
    endfunction

    function automatic int rstDuty(input int minDuty);
`ifdef FADE_GEN_GAMMA_EN
        return 0 * minDuty;
`else
        return minDuty;
`endif
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic rstPulse();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic startPulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Drive one tick and compare against the expectation queued with it
    task automatic sbTick(input int lvl, input logic dn, input logic bs, input logic st, input string nm);
        exp_t e;
        logic oDone, oBusy;
        sbq.push_back('{8'(g(lvl)), dn, bs});
        @(negedge clk) begin tick = 1'b1; start = st; end
        @(negedge clk) begin tick = 1'b0; start = 1'b0; end
        oDone = selDone;
        oBusy = selBusy;
        repeat (2) @(negedge clk);
        e = sbq.pop_front();
        check({nm, " duty"}, int'(selDuty), int'(e.duty));
        check({nm, " cycleDone"}, int'(oDone), int'(e.done));
        check({nm, " busy"}, int'(oBusy), int'(e.busy));
    endtask

    task automatic fastTick(output logic dn);
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        dn = selDone;
    endtask

    initial begin
        int m, lvl, doneCnt, doneIdx;
        logic dn;

        tbl[0]  = '{1'b0,  3, 1'b0, 1'b1};
        tbl[1]  = '{1'b0,  6, 1'b0, 1'b1};
        tbl[2]  = '{1'b0,  9, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 10, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 10, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 10, 1'b0, 1'b1};
        tbl[6]  = '{1'b1,  7, 1'b0, 1'b1};
        tbl[7]  = '{1'b0,  4, 1'b0, 1'b1};
        tbl[8]  = '{1'b0,  1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0,  0, 1'b0, 1'b1};
        tbl[10] = '{1'b0,  0, 1'b0, 1'b1};
        tbl[11] = '{1'b0,  0, 1'b1, 1'b0};

        sel = 0; enable = 1'b1; oneShot = 1'b0; start = 1'b0; tick = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst duty0", int'(duty0), rstDuty(1));
        check("rst duty1", int'(duty1), rstDuty(0));
        check("rst busy0", int'(busy0), 0);
        check("rst busy2", int'(busy2), 0);
        check("rst done0", int'(done0), 0);
        rst = 1'b0;

        // Free-running heartbeat with default limits
        for (int k = 1; k <= 516; k++) begin
            m   = ((k - 1) % 506) + 1;
            lvl = (m <= 253) ? (1 + m) : (254 - (m - 253));
            sbTick(lvl, m == 506, 1'b1, 1'b0, $sformatf("heartbeat t%0d", k));
        end

        // Asynchronous reset in the middle of a fall
        rstPulse();
        for (int k = 0; k < 407; k++) fastTick(dn);
        repeat (2) @(negedge clk);
        check("midfall level", int'(duty0), g(100));
        @(negedge clk) begin oneShot = 1'b1; start = 1'b1; end
        #1 rst = 1'b1;
        #1;
        check("async rst duty", int'(duty0), rstDuty(1));
        check("async rst busy", int'(busy0), 0);
        check("async rst done", int'(done0), 0);
        repeat (3) @(negedge clk);
        check("rst held busy", int'(busy0), 0);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("start during rst ignored", int'(busy0), 0);

        // Dropping enable at level 50 finishes the envelope then idles
        oneShot = 1'b0;
        rstPulse();
        for (int k = 0; k < 49; k++) fastTick(dn);
        repeat (2) @(negedge clk);
        check("enable drop level", int'(duty0), g(50));
        enable = 1'b0;
        doneCnt = 0; doneIdx = -1;
        for (int k = 1; k <= 470; k++) begin
            fastTick(dn);
            if (dn) begin doneCnt++; doneIdx = k; end
        end
        repeat (2) @(negedge clk);
        check("enable drop done count", doneCnt, 1);
        check("enable drop done tick", doneIdx, 457);
        check("enable drop busy", int'(busy0), 0);
        check("enable drop duty", int'(duty0), g(1));

        // One-shot flash with holds
        sel = 1; enable = 1'b1; oneShot = 1'b1;
        rstPulse();
        repeat (3) @(negedge clk);
        check("oneshot idle busy", int'(busy1), 0);
        startPulse();
        @(negedge clk);
        check("oneshot start busy", int'(busy1), 1);
        for (int i = 0; i < 12; i++)
            sbTick(tbl[i].duty, tbl[i].done, tbl[i].busy, tbl[i].st, $sformatf("flash t%0d", i + 1));
        startPulse();
        sbTick(3, 1'b0, 1'b1, 1'b0, "retrigger");

        // Full-range single-step envelope
        sel = 2;
        rstPulse();
        startPulse();
        sbTick(255, 1'b0, 1'b1, 1'b0, "bigstep t1");
        sbTick(0, 1'b1, 1'b0, 1'b0, "bigstep t2");
`ifdef FADE_GEN_GAMMA_EN
        startPulse();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        check("gamma latency old", int'(duty2), 0);
        @(negedge clk);
        check("gamma latency new", int'(duty2), 255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
